// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Merges the IF, ID and MEM stall requests with the EX branch decision into a
// per-stage hold vector, bubble strobes for IF/ID and ID/EX, and PC redirects.
// A taken branch that arrives while a fetch is outstanding is parked in
// REDIR_WAIT until the fetch completes. The redirect is then issued and the
// late fetch word is discarded.
// Optional build macro: PIPE_CTRL_PERF_EN adds stall and flush cycle counters.
// Without it, both counter outputs are tied to zero.
module pipeline_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_stall_req_i,
    input  logic              id_stall_req_i,
    input  logic              mem_stall_req_i,
    input  logic              ex_branch_taken_i,
    input  logic [ADDR_W-1:0] ex_branch_target_i,
    output logic [4:0]        lock_o,
    output logic              IFID_clean_o,
    output logic              IDEX_clean_o,
    output logic              pc_redirect_o,
    output logic [ADDR_W-1:0] pc_target_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    // Hold patterns, bit order: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB
    localparam logic [4:0] LOCK_NONE = 5'b00000;
    localparam logic [4:0] LOCK_PC   = 5'b00001;
    localparam logic [4:0] LOCK_ID   = 5'b00011;
    localparam logic [4:0] LOCK_MEM  = 5'b01111;

    typedef enum logic {
        RUN        = 1'b0,
        REDIR_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pend_tgt;

    state_t            w_state_nxt;
    logic              w_latch_tgt;
    logic [4:0]        w_lock;
    logic              w_ifid_clean;
    logic              w_idex_clean;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;

    // Decode the hold, bubble and redirect controls from the inputs and the current state.
    always_comb begin
        // NOTE: every signal gets a default first, so no branch leaves one unassigned and infers a latch.
        w_lock       = LOCK_NONE;
        w_ifid_clean = 1'b0;
        w_idex_clean = 1'b0;
        w_redirect   = 1'b0;
        w_target     = r_pend_tgt;
        w_state_nxt  = r_state;
        w_latch_tgt  = 1'b0;

        if (!rst) begin
            // During reset, both pipeline registers are bubbled and no redirect is issued.
            w_ifid_clean = 1'b1;
            w_idex_clean = 1'b1;
            w_target     = '0;
            w_state_nxt  = RUN;
        end else if (r_state == REDIR_WAIT) begin
            // EX and EX/MEM hold bubbles here, so branch and mem-stall requests cannot be genuine.
            if (if_stall_req_i) begin
                w_lock       = LOCK_PC;
                w_ifid_clean = 1'b1;
                w_idex_clean = 1'b1;
            end else begin
                // Fetch finished: issue the parked redirect and drop the stale fetch word.
                w_redirect   = 1'b1;
                w_ifid_clean = 1'b1;
                w_state_nxt  = RUN;
            end
        end else begin
            if (mem_stall_req_i) begin
                // Freeze everything up to EX/MEM; a branch held in EX is taken once the stall clears.
                w_lock = LOCK_MEM;
            end else if (ex_branch_taken_i && !if_stall_req_i) begin
                w_ifid_clean = 1'b1;
                w_idex_clean = 1'b1;
                w_redirect   = 1'b1;
                w_target     = ex_branch_target_i;
            end else if (ex_branch_taken_i) begin
                // A fetch is still in flight: park the target until the fetch completes.
                w_lock       = LOCK_PC;
                w_ifid_clean = 1'b1;
                w_idex_clean = 1'b1;
                w_latch_tgt  = 1'b1;
                w_state_nxt  = REDIR_WAIT;
            end else if (id_stall_req_i) begin
                // Load-use hazard: hold PC and IF/ID, and insert a bubble into EX.
                w_lock       = LOCK_ID;
                w_idex_clean = 1'b1;
            end else if (if_stall_req_i) begin
                w_lock       = LOCK_PC;
                w_ifid_clean = 1'b1;
            end
        end
    end

    assign lock_o        = w_lock;
    assign IFID_clean_o  = w_ifid_clean;
    assign IDEX_clean_o  = w_idex_clean;
    assign pc_redirect_o = w_redirect;
    assign pc_target_o   = w_target;

    // Sequencer state and the parked branch target; a reset drops any pending redirect.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (!rst) begin
            r_state    <= RUN;
            r_pend_tgt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch_tgt) begin
                r_pend_tgt <= ex_branch_target_i;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_branch_accept;

    // A branch is counted once, when RUN accepts it; completing REDIR_WAIT does not count it again.
    assign w_branch_accept = (r_state == RUN) && !mem_stall_req_i && ex_branch_taken_i;

    // Counters wrap naturally; stall cycles are the cycles with any hold bit set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (|w_lock) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_branch_accept) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios and a randomized run for pipeline_ctrl.
// The randomized run is checked against a reference model that tracks a queue of parked redirects.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_s, id_s, mem_s, br;
    logic [31:0] tgt;
    logic [4:0]  lock;
    logic        ifid, idex, redir;
    logic [31:0] ptgt;
    logic [31:0] scnt, fcnt;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .if_stall_req_i     (if_s),
        .id_stall_req_i     (id_s),
        .mem_stall_req_i    (mem_s),
        .ex_branch_taken_i  (br),
        .ex_branch_target_i (tgt),
        .lock_o             (lock),
        .IFID_clean_o       (ifid),
        .IDEX_clean_o       (idex),
        .pc_redirect_o      (redir),
        .pc_target_o        (ptgt),
        .stall_cnt_o        (scnt),
        .flush_cnt_o        (fcnt)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs and wait until the outputs have settled, half a cycle away from the edge.
    task automatic drive(input logic r, input logic m, input logic b, input logic i,
                         input logic d, input logic [31:0] t);
        rst = r; mem_s = m; br = b; if_s = i; id_s = d; tgt = t;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [39:0] exp_v;
        exp_v = {5'b00000, 1'b1, 1'b1, 1'b0, 32'h0};
        drive(0, 0, 0, 0, 0, 32'h55);
        checks++;
        if ({lock, ifid, idex, redir, ptgt} !== exp_v) begin
            errors++; $display("FAIL reset_c0: got %h want %h", {lock, ifid, idex, redir, ptgt}, exp_v);
        end
        tick();
        drive(0, 1, 1, 1, 1, 32'h77);
        checks++;
        if ({lock, ifid, idex, redir, ptgt} !== exp_v) begin
            errors++; $display("FAIL reset_c1: got %h want %h", {lock, ifid, idex, redir, ptgt}, exp_v);
        end
        checks++;
        if ({scnt, fcnt} !== 64'h0) begin
            errors++; $display("FAIL reset_cnt: got %h/%h want 0/0", scnt, fcnt);
        end
        tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        checks++;
        if ({lock, ifid, idex, redir, ptgt} !== 40'h0) begin
            errors++; $display("FAIL reset_release: got %h want 0", {lock, ifid, idex, redir, ptgt});
        end
        tick();
    endtask

    task automatic test_mem_stall_branch();
        logic [39:0] exp_v;
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 1, 0, 0, 32'h300);
            exp_v = {5'b01111, 1'b0, 1'b0, 1'b0, 32'h0};
            checks++;
            if ({lock, ifid, idex, redir, ptgt} !== exp_v) begin
                errors++; $display("FAIL mem_stall_c%0d: got %h want %h", c, {lock, ifid, idex, redir, ptgt}, exp_v);
            end
            tick();
        end
        drive(1, 0, 1, 0, 0, 32'h300);
        exp_v = {5'b00000, 1'b1, 1'b1, 1'b1, 32'h300};
        checks++;
        if ({lock, ifid, idex, redir, ptgt} !== exp_v) begin
            errors++; $display("FAIL mem_stall_release: got %h want %h", {lock, ifid, idex, redir, ptgt}, exp_v);
        end
        tick();
    endtask

    task automatic test_branch_direct();
        logic [39:0] exp_v;
        drive(1, 0, 1, 0, 0, 32'h100);
        exp_v = {5'b00000, 1'b1, 1'b1, 1'b1, 32'h100};
        checks++;
        if ({lock, ifid, idex, redir, ptgt} !== exp_v) begin
            errors++; $display("FAIL branch_direct: got %h want %h", {lock, ifid, idex, redir, ptgt}, exp_v);
        end
        tick();
    endtask

    task automatic test_branch_if_stall();
        logic [39:0] exp_v;
        drive(1, 0, 1, 1, 0, 32'h200);
        exp_v = {5'b00001, 1'b1, 1'b1, 1'b0, 32'h0};
        checks++;
        if ({lock, ifid, idex, redir, ptgt} !== exp_v) begin
            errors++; $display("FAIL branch_park: got %h want %h", {lock, ifid, idex, redir, ptgt}, exp_v);
        end
        tick();
        // Branch and mem-stall requests seen while waiting must be ignored.
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 1, 1, 1, 32'hDEAD);
            exp_v = {5'b00001, 1'b1, 1'b1, 1'b0, 32'h200};
            checks++;
            if ({lock, ifid, idex, redir, ptgt} !== exp_v) begin
                errors++; $display("FAIL redir_wait_c%0d: got %h want %h", c, {lock, ifid, idex, redir, ptgt}, exp_v);
            end
            tick();
        end
        drive(1, 0, 0, 0, 0, 32'h0);
        exp_v = {5'b00000, 1'b1, 1'b0, 1'b1, 32'h200};
        checks++;
        if ({lock, ifid, idex, redir, ptgt} !== exp_v) begin
            errors++; $display("FAIL redir_issue: got %h want %h", {lock, ifid, idex, redir, ptgt}, exp_v);
        end
        tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        exp_v = {5'b00000, 1'b0, 1'b0, 1'b0, 32'h200};
        checks++;
        if ({lock, ifid, idex, redir, ptgt} !== exp_v) begin
            errors++; $display("FAIL redir_done: got %h want %h", {lock, ifid, idex, redir, ptgt}, exp_v);
        end
        tick();
    endtask

    task automatic test_id_if_stall();
        logic [39:0] exp_v;
        drive(1, 0, 0, 1, 1, 32'h0);
        exp_v = {5'b00011, 1'b0, 1'b1, 1'b0, 32'h200};
        checks++;
        if ({lock, ifid, idex, redir, ptgt} !== exp_v) begin
            errors++; $display("FAIL id_if_stall: got %h want %h", {lock, ifid, idex, redir, ptgt}, exp_v);
        end
        tick();
        drive(1, 0, 0, 1, 0, 32'h0);
        exp_v = {5'b00001, 1'b1, 1'b0, 1'b0, 32'h200};
        checks++;
        if ({lock, ifid, idex, redir, ptgt} !== exp_v) begin
            errors++; $display("FAIL if_stall_only: got %h want %h", {lock, ifid, idex, redir, ptgt}, exp_v);
        end
        tick();
    endtask

    task automatic test_perf();
        logic [31:0] exp_s, exp_f;
`ifdef PIPE_CTRL_PERF_EN
        exp_s = 32'd5; exp_f = 32'd1;
`else
        exp_s = 32'd0; exp_f = 32'd0;
`endif
        drive(0, 0, 0, 0, 0, 32'h0); tick();
        drive(1, 0, 1, 1, 0, 32'h200); tick();
        for (int c = 0; c < 4; c++) begin
            drive(1, 0, 0, 1, 0, 32'h0); tick();
        end
        drive(1, 0, 0, 0, 0, 32'h0); tick();
        drive(1, 0, 0, 0, 0, 32'h0); tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        checks++;
        if ({scnt, fcnt} !== {exp_s, exp_f}) begin
            errors++; $display("FAIL perf_counts: got stall=%0d flush=%0d want stall=%0d flush=%0d", scnt, fcnt, exp_s, exp_f);
        end
        tick();
        // A reset while a redirect is parked must drop that redirect.
        drive(1, 0, 1, 1, 0, 32'h400); tick();
        drive(0, 0, 0, 1, 0, 32'h0); tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        checks++;
        if ({lock, ifid, idex, redir, ptgt} !== 40'h0) begin
            errors++; $display("FAIL reset_drops_redir: got %h want 0", {lock, ifid, idex, redir, ptgt});
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] parked[$];
        logic [31:0] last_tgt;
        logic [31:0] m_scnt, m_fcnt;
        logic [4:0]  e_lock;
        logic        e_ifid, e_idex, e_redir;
        logic [31:0] e_tgt;
        logic        r, m, b, i, d;
        logic [31:0] t;
        last_tgt = 0; m_scnt = 0; m_fcnt = 0;
        for (int n = 0; n < 2000; n++) begin
            r = (n == 0) ? 1'b0 : ($urandom_range(49) != 0);
            m = ($urandom_range(4) == 0);
            b = ($urandom_range(3) == 0);
            i = ($urandom_range(2) == 0);
            d = ($urandom_range(3) == 0);
            t = $urandom;
            drive(r, m, b, i, d, t);
            e_lock = 5'b00000; e_ifid = 0; e_idex = 0; e_redir = 0; e_tgt = last_tgt;
            if (!r) begin
                e_ifid = 1; e_idex = 1; e_tgt = 0;
            end else if (parked.size() != 0) begin
                if (i) begin
                    e_lock = 5'b00001; e_ifid = 1; e_idex = 1;
                end else begin
                    e_redir = 1; e_ifid = 1;
                end
            end else if (m) begin
                e_lock = 5'b01111;
            end else if (b && !i) begin
                e_ifid = 1; e_idex = 1; e_redir = 1; e_tgt = t;
            end else if (b) begin
                e_lock = 5'b00001; e_ifid = 1; e_idex = 1;
            end else if (d) begin
                e_lock = 5'b00011; e_idex = 1;
            end else if (i) begin
                e_lock = 5'b00001; e_ifid = 1;
            end
            checks++;
            if ({lock, ifid, idex, redir, ptgt} !== {e_lock, e_ifid, e_idex, e_redir, e_tgt}) begin
                errors++;
                $display("FAIL random_c%0d: got %h want %h", n, {lock, ifid, idex, redir, ptgt},
                         {e_lock, e_ifid, e_idex, e_redir, e_tgt});
            end
            if (n > 0) begin
                checks++;
                if ({scnt, fcnt} !== {m_scnt, m_fcnt}) begin
                    errors++; $display("FAIL random_cnt_c%0d: got %0d/%0d want %0d/%0d", n, scnt, fcnt, m_scnt, m_fcnt);
                end
            end
            // Advance the model to the state after this edge.
            if (!r) begin
                parked.delete(); last_tgt = 0; m_scnt = 0; m_fcnt = 0;
            end else begin
`ifdef PIPE_CTRL_PERF_EN
                if (e_lock != 0) m_scnt = m_scnt + 1;
                if (parked.size() == 0 && !m && b) m_fcnt = m_fcnt + 1;
`endif
                if (parked.size() != 0) begin
                    if (!i) void'(parked.pop_front());
                end else if (!m && b && i) begin
                    parked.push_back(t);
                    last_tgt = t;
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 0; if_s = 0; id_s = 0; mem_s = 0; br = 0; tgt = 0;
        test_reset();
        test_mem_stall_branch();
        test_branch_direct();
        test_branch_if_stall();
        test_id_if_stall();
        test_perf();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
